// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - six-digit multiplexed 7-segment scan driver with per-frame snapshot
module seg7_scan_driver #(
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYC      = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk_50Mhz,
    input  logic        rst,
    input  logic [23:0] dispbuf,
    input  logic        blank_lz,
    input  logic [5:0]  dp_mask,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [5:0]  dig_sel,
    output logic        frame_tick
);

    localparam int              CW        = $clog2(SCAN_DIV);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]   CNT_BLANK = CW'(BLANK_CYC);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic [6:0]      SEG_OFF   = {7{SEG_ACTIVE_LOW}};
    localparam logic            DP_OFF    = SEG_ACTIVE_LOW;
    localparam logic [5:0]      DIG_OFF   = {6{DIG_ACTIVE_LOW}};

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [23:0]   snap_q, snap_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [5:0]    dig_q, dig_d;
    logic          ft_q, ft_d;

    logic          frame_start;
    logic          cnt_wrap;
    logic [3:0]    nib;
    logic          dp_bit;
    logic          suppress;
    logic          lit;

    // Active-high segment pattern {g,f,e,d,c,b,a}; non-BCD codes show a dash.
    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0:    decode = 7'h3F;
            4'h1:    decode = 7'h06;
            4'h2:    decode = 7'h5B;
            4'h3:    decode = 7'h4F;
            4'h4:    decode = 7'h66;
            4'h5:    decode = 7'h6D;
            4'h6:    decode = 7'h7D;
            4'h7:    decode = 7'h07;
            4'h8:    decode = 7'h7F;
            4'h9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    always_comb begin
        frame_start = (cnt_q == '0) && (idx_q == 3'd0);
        cnt_wrap    = (cnt_q == CNT_LAST);
        cnt_d       = cnt_wrap ? '0 : cnt_q + CNT_ONE;
        idx_d       = idx_q;
        if (cnt_wrap) begin
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end
        snap_d = frame_start ? dispbuf : snap_q;

        nib    = snap_q[23:20];
        dp_bit = dp_mask[5];
        case (idx_q)
            3'd0: begin nib = snap_q[3:0];   dp_bit = dp_mask[0]; end
            3'd1: begin nib = snap_q[7:4];   dp_bit = dp_mask[1]; end
            3'd2: begin nib = snap_q[11:8];  dp_bit = dp_mask[2]; end
            3'd3: begin nib = snap_q[15:12]; dp_bit = dp_mask[3]; end
            3'd4: begin nib = snap_q[19:16]; dp_bit = dp_mask[4]; end
            default: ;
        endcase

        // Only the leftmost digit is eligible for leading-zero blanking.
        suppress = blank_lz && (idx_q == 3'd5) && (snap_q[23:20] == 4'h0);
        lit      = (cnt_q >= CNT_BLANK) && !suppress;

        seg_d = (lit ? decode(nib) : 7'h00) ^ SEG_OFF;
        dp_d  = (lit & dp_bit) ^ DP_OFF;
        dig_d = (lit ? (6'b000001 << idx_q) : 6'h00) ^ DIG_OFF;
        ft_d  = frame_start;
    end

    always_ff @(posedge clk_50Mhz) begin
        if (rst) begin
            cnt_q  <= '0;
            idx_q  <= 3'd0;
            snap_q <= 24'h000000;
            seg_q  <= SEG_OFF;
            dp_q   <= DP_OFF;
            dig_q  <= DIG_OFF;
            ft_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            snap_q <= snap_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
            dig_q  <= dig_d;
            ft_q   <= ft_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign dig_sel    = dig_q;
    assign frame_tick = ft_q;

endmodule
